// File: rtl/rect_fill_if.sv
// Command, framebuffer-write and status signals of the rectangle-fill engine.
// The slave modport is the engine's view; the master modport is the view of
// whatever issues commands and owns the framebuffer port.
interface rect_fill_if #(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic [8:0]         cmd_x0;
  logic [7:0]         cmd_y0;
  logic [8:0]         cmd_x1;
  logic [7:0]         cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic               fb_we;
  logic               fb_ready;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               busy;
  logic               done;
  logic               err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, fb_ready,
    output cmd_ready, fb_we, fb_addr, fb_data, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, fb_ready,
    input  cmd_ready, fb_we, fb_addr, fb_data, busy, done, err
  );
endinterface

// File: rtl/rect_fill.sv
// Rectangle-fill / screen-clear engine for the RGB332 framebuffer.
// One command at a time: capture, clip/validate in SETUP, then stream one
// pixel write per accepted cycle in raster order, then pulse done.
module rect_fill #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  rect_fill_if.slave bus
);

  localparam logic [8:0] X_LIM = 9'(H_RES);
  localparam logic [7:0] Y_LIM = 8'(V_RES);
  localparam logic [8:0] X_MAX = 9'(H_RES - 1);
  localparam logic [7:0] Y_MAX = 8'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_op;
  logic [8:0]         r_x0;
  logic [7:0]         r_y0;
  logic [8:0]         r_x1;
  logic [7:0]         r_y1;
  logic [COLOR_W-1:0] r_color;
  logic [8:0]         r_x;
  logic [7:0]         r_y;
  logic [ADDR_W-1:0]  r_row_base;
  logic               r_fb_we;
  logic [ADDR_W-1:0]  r_fb_addr;
  logic [COLOR_W-1:0] r_fb_data;
  logic               r_done;
  logic               r_err;

  logic [8:0]         w_x0;
  logic [7:0]         w_y0;
  logic [8:0]         w_x1;
  logic [7:0]         w_y1;
  logic               w_reject;
  logic [ADDR_W-1:0]  w_row_base;
  logic               w_row_end;
  logic               w_last;
  logic [ADDR_W-1:0]  w_next_row;

  // Clip and validate the captured command; a clear simply substitutes the full screen.
  always_comb begin
    w_x0     = r_x0;
    w_y0     = r_y0;
    w_x1     = (r_x1 > X_MAX) ? X_MAX : r_x1;
    w_y1     = (r_y1 > Y_MAX) ? Y_MAX : r_y1;
    w_reject = (r_x0 >= X_LIM) || (r_y0 >= Y_LIM) || (r_x0 > r_x1) || (r_y0 > r_y1);
    if (r_op) begin
      w_x0     = '0;
      w_y0     = '0;
      w_x1     = X_MAX;
      w_y1     = Y_MAX;
      w_reject = 1'b0;
    end
  end

  // Constant-coefficient product, only consumed in SETUP; DRAW advances rows by addition.
  assign w_row_base = ADDR_W'(w_y0) * ROW_STEP;

  assign w_row_end  = (r_x == r_x1);
  assign w_last     = w_row_end && (r_y == r_y1);
  assign w_next_row = r_row_base + ROW_STEP;

  // Command FSM; every output except cmd_ready/busy is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_color    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_op    <= bus.cmd_op;
            r_x0    <= bus.cmd_x0;
            r_y0    <= bus.cmd_y0;
            r_x1    <= bus.cmd_x1;
            r_y1    <= bus.cmd_y1;
            r_color <= bus.cmd_color;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_reject) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            // Clipped bounds overwrite the raw command; x0 is needed again at each row wrap.
            r_x0       <= w_x0;
            r_x1       <= w_x1;
            r_y1       <= w_y1;
            r_x        <= w_x0;
            r_y        <= w_y0;
            r_row_base <= w_row_base;
            r_fb_we    <= 1'b1;
            r_fb_addr  <= w_row_base + ADDR_W'(w_x0);
            r_fb_data  <= r_color;
            r_state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          // Without fb_ready the write request simply stays where it is.
          if (bus.fb_ready) begin
            if (w_last) begin
              r_fb_we <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_row_end) begin
              r_x        <= r_x0;
              r_y        <= r_y + 8'd1;
              r_row_base <= w_next_row;
              r_fb_addr  <= w_next_row + ADDR_W'(r_x0);
            end else begin
              r_x       <= r_x + 9'd1;
              r_fb_addr <= r_fb_addr + ADDR_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.fb_we     = r_fb_we;
  assign bus.fb_addr   = r_fb_addr;
  assign bus.fb_data   = r_fb_data;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: table of commands with hand-written
// write counts / reject flags, a reference raster model feeding a scoreboard
// queue, plus hand sequences for backpressure and reset mid-draw.
module tb_rect_fill;

  localparam int H_RES   = 320;
  localparam int V_RES   = 240;
  localparam int ADDR_W  = 17;
  localparam int COLOR_W = 8;

  typedef struct {
    string name;
    bit    op;
    int    x0;
    int    y0;
    int    x1;
    int    y1;
    int    color;
    bit    exp_err;
    int    n;
  } cmd_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rect_fill_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

  rect_fill #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W),
    .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_t  exp_q[$];
  int   checks        = 0;
  int   errors        = 0;
  int   cyc           = 0;
  int   wr_cnt        = 0;
  int   done_cnt      = 0;
  int   err_cnt       = 0;
  int   last_done_cyc = -1;
  int   last_err_cyc  = -1;
  bit   err_busy      = 1'b0;
  cmd_t tbl[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard side: every accepted write is popped and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fb_we && bus.fb_ready) begin
        wr_t e;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(bus.fb_addr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(bus.fb_addr), e.addr);
          chk("wr_data", int'(bus.fb_data), e.data);
        end
      end
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (bus.err) begin
        err_cnt++;
        last_err_cyc = cyc;
        err_busy = bus.busy;
      end
    end
  end

  // Reference raster model: expected writes in row-major order after clipping.
  task automatic push_expected(input cmd_t c);
    int xa, ya, xb, yb;
    if (c.op) begin
      xa = 0; ya = 0; xb = H_RES - 1; yb = V_RES - 1;
    end else begin
      if (c.x0 >= H_RES || c.y0 >= V_RES || c.x0 > c.x1 || c.y0 > c.y1) return;
      xa = c.x0; ya = c.y0;
      xb = (c.x1 > H_RES - 1) ? H_RES - 1 : c.x1;
      yb = (c.y1 > V_RES - 1) ? V_RES - 1 : c.y1;
    end
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        exp_q.push_back('{addr: y * H_RES + x, data: c.color});
  endtask

  // Present a command and wait for its acceptance; t is the cycle ending in the accepting edge.
  task automatic send(input cmd_t c, output int t);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = c.op;
    bus.cmd_x0    = 9'(c.x0);
    bus.cmd_y0    = 8'(c.y0);
    bus.cmd_x1    = 9'(c.x1);
    bus.cmd_y1    = 8'(c.y1);
    bus.cmd_color = 8'(c.color);
    t = -1;
    for (int i = 0; i < 50 && t < 0; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) t = cyc;
    end
    if (t < 0) chk({c.name, "_accept"}, 0, 1);
    else begin
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input cmd_t c);
    int t, n0, e0, d0;
    bit ended;
    n0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    push_expected(c);
    send(c, t);
    if (t < 0) begin
      exp_q.delete();
      return;
    end
    ended = 1'b0;
    for (int i = 0; i < c.n + 20 && !ended; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0 || err_cnt != e0) ended = 1'b1;
    end
    chk({c.name, "_ended"}, int'(ended), 1);
    if (c.exp_err) begin
      chk({c.name, "_err_pulses"}, err_cnt - e0, 1);
      chk({c.name, "_err_cycle"}, last_err_cyc - t, 2);
      chk({c.name, "_busy_at_err"}, int'(err_busy), 0);
      chk({c.name, "_done_pulses"}, done_cnt - d0, 0);
      chk({c.name, "_writes"}, wr_cnt - n0, 0);
    end else begin
      chk({c.name, "_done_pulses"}, done_cnt - d0, 1);
      chk({c.name, "_done_cycle"}, last_done_cyc - t, c.n + 2);
      chk({c.name, "_writes"}, wr_cnt - n0, c.n);
      chk({c.name, "_err_pulses"}, err_cnt - e0, 0);
      chk({c.name, "_busy_in_done"}, int'(bus.busy), 1);
      chk({c.name, "_ready_in_done"}, int'(bus.cmd_ready), 0);
    end
    chk({c.name, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk); #1;
    chk({c.name, "_ready_after"}, int'(bus.cmd_ready), 1);
    chk({c.name, "_done_cleared"}, int'(bus.done), 0);
    $display("cmd %s: accepted T=%0d writes=%0d done=%0d err=%0d end_cycle=%0d",
             c.name, t, wr_cnt - n0, done_cnt - d0, err_cnt - e0,
             c.exp_err ? last_err_cyc : last_done_cyc);
  endtask

  task automatic backpressure();
    cmd_t c;
    int t, n0, e0, d0;
    c = '{"bp_row", 1'b0, 0, 0, 2, 0, 8'h11, 1'b0, 3};
    n0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    push_expected(c);
    send(c, t);
    if (t < 0) return;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.fb_ready = !(cyc == t + 3 || cyc == t + 4);
      @(negedge clk); #1;
      if (cyc >= t + 3 && cyc <= t + 5) begin
        chk("bp_hold_we", int'(bus.fb_we), 1);
        chk("bp_hold_addr", int'(bus.fb_addr), 1);
      end
    end
    bus.fb_ready = 1'b1;
    chk("bp_done_pulses", done_cnt - d0, 1);
    chk("bp_done_cycle", last_done_cyc - t, 7);
    chk("bp_writes", wr_cnt - n0, 3);
    chk("bp_err_pulses", err_cnt - e0, 0);
    chk("bp_pending_writes", exp_q.size(), 0);
    exp_q.delete();
    $display("cmd bp_row: accepted T=%0d writes=%0d done_cycle=%0d", t, wr_cnt - n0, last_done_cyc);
  endtask

  task automatic reset_mid_draw();
    cmd_t c;
    int t, n0, e0, d0;
    bit reached;
    c = '{"clear_abort", 1'b1, 0, 0, 0, 0, 8'h42, 1'b0, 76800};
    n0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    push_expected(c);
    send(c, t);
    if (t < 0) return;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk); #1;
      if (wr_cnt - n0 >= 100) reached = 1'b1;
    end
    chk("abort_reached_100", int'(reached), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_fb_we", int'(bus.fb_we), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ready", int'(bus.cmd_ready), 1);
    chk("abort_addr", int'(bus.fb_addr), 0);
    chk("abort_data", int'(bus.fb_data), 0);
    repeat (6) @(negedge clk);
    #1;
    chk("abort_writes", wr_cnt - n0, 100);
    chk("abort_done_pulses", done_cnt - d0, 0);
    chk("abort_err_pulses", err_cnt - e0, 0);
    exp_q.delete();
    $display("cmd clear_abort: accepted T=%0d writes_before_reset=%0d", t, wr_cnt - n0);
  endtask

  initial begin
    tbl[0] = '{"single",       1'b0,   0,   0,   0,   0, 8'hE0, 1'b0, 1};
    tbl[1] = '{"small_rect",   1'b0,   2,   1,   4,   2, 8'h1C, 1'b0, 6};
    tbl[2] = '{"clip_corner",  1'b0, 318, 238, 400, 255, 8'h03, 1'b0, 4};
    tbl[3] = '{"rej_x0_gt_x1", 1'b0,  10,   5,   9,   5, 8'h55, 1'b1, 0};
    tbl[4] = '{"rej_x0_off",   1'b0, 320,   0, 330,   0, 8'h55, 1'b1, 0};
    tbl[5] = '{"rej_y0_off",   1'b0,   0, 240,   0, 250, 8'h55, 1'b1, 0};
    tbl[6] = '{"rej_y0_gt_y1", 1'b0,   5,   7,   5,   3, 8'h55, 1'b1, 0};
    tbl[7] = '{"rect_mid",     1'b0, 100,  50, 103,  51, 8'h5A, 1'b0, 8};
    tbl[8] = '{"clear",        1'b1,  10,  10,   3,   3, 8'hFF, 1'b0, 76800};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;
    bus.fb_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fb_we", int'(bus.fb_we), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_addr", int'(bus.fb_addr), 0);
    chk("rst_data", int'(bus.fb_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(bus.cmd_ready), 1);

    for (int i = 0; i < 9; i++) run_cmd(tbl[i]);
    backpressure();
    reset_mid_draw();
    run_cmd(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
